// File: rtl/store_unit.sv
// store_unit: turns one SB/SH/SW request into word-aligned memory write beats.
// Stores that cross a word boundary become two beats (beat0 at the lower word,
// beat1 at the next word), or are rejected with err when splitting is disabled.
module store_unit #(
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       store_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_t;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  state_t state;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              legal;
  logic [1:0]        offset;
  logic [3:0]        base_be;
  logic [31:0]       base_data;
  logic [7:0]        be_wide;
  logic [63:0]       data_wide;
  logic              need_split;
  logic              reject;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] next_word;

  logic              split_q;
  logic [ADDR_W-1:0] b1_addr;
  logic [3:0]        b1_be;
  logic [31:0]       b1_data;

  // Only opcode and funct3 matter; the remaining instruction bits are ignored.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign offset    = address[1:0];
  assign word_addr = {address[ADDR_W-1:2], 2'b00};
  assign next_word = word_addr + ADDR_W'(4);
  assign in_ready  = (state == IDLE);

  // Decode size into an unshifted lane mask and zero-extended data; the
  // double-width shift below then yields beat0 in the low half and beat1 in
  // the high half, so both beats of a split come from one expression.
  always_comb begin
    legal     = 1'b0;
    base_be   = 4'b1111;
    base_data = store_val;
    if (opcode == OPCODE_STORE) begin
      case (funct3)
        3'b000: begin
          legal     = 1'b1;
          base_be   = 4'b0001;
          base_data = {24'h0, store_val[7:0]};
        end
        3'b001: begin
          legal     = 1'b1;
          base_be   = 4'b0011;
          base_data = {16'h0, store_val[15:0]};
        end
        3'b010: begin
          legal     = 1'b1;
          base_be   = 4'b1111;
          base_data = store_val;
        end
        default: begin
          legal     = 1'b0;
          base_be   = 4'b1111;
          base_data = store_val;
        end
      endcase
    end
  end

  assign be_wide    = {4'b0000, base_be} << offset;
  assign data_wide  = {32'h0, base_data} << {offset, 3'b000};
  assign need_split = |be_wide[7:4];
  assign reject     = !legal || (need_split && !SPLIT_MISALIGNED);

  // Request FSM with registered memory and response outputs; beat1 fields are
  // captured at accept time so later input changes cannot disturb the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      split_q   <= 1'b0;
      b1_addr   <= '0;
      b1_be     <= '0;
      b1_data   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            split_q <= need_split;
            b1_addr <= next_word;
            b1_be   <= be_wide[7:4];
            b1_data <= data_wide[63:32];
            if (reject) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= word_addr;
              mem_be    <= be_wide[3:0];
              mem_wdata <= data_wide[31:0];
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (split_q) begin
              state     <= BEAT1;
              mem_addr  <= b1_addr;
              mem_be    <= b1_be;
              mem_wdata <= b1_data;
            end else begin
              state     <= RESP;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= '0;
              mem_wdata <= '0;
              done      <= 1'b1;
              err       <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
            err       <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: drives store_unit with directed and random stores and checks
// every beat against a byte-by-byte model of which memory bytes get written.
module tb_store_unit;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instruction, address, store_val;
  logic        mem_req, mem_ack, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        in_valid2, in_ready2, mem_req2, mem_ack2, done2, err2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_be2;

  int checks   = 0;
  int failures = 0;

  int          exp_nb;
  logic        exp_err;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be   [2];
  logic [31:0] exp_data [2];

  always #5 clk = ~clk;

  store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .address(address), .store_val(store_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done(done), .err(err)
  );

  store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .instruction(instruction), .address(address), .store_val(store_val),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_be(mem_be2),
    .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .done(done2), .err(err2)
  );

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [31:0] junk);
    return {junk[31:15], f3, junk[11:7], op};
  endfunction

  // Model: a store of N bytes writes byte address a+k with store_val byte k;
  // consecutive bytes sharing a word form one beat.
  task automatic compute_expected(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] sv, input bit split_en);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] ba, w;
    int          size, lane;
    op = ins[6:0];
    f3 = ins[14:12];
    exp_nb  = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_addr[i] = '0; exp_be[i] = '0; exp_data[i] = '0;
    end
    if (op != OP_STORE || f3 > 3'd2) begin
      exp_err = 1'b1;
      return;
    end
    size = 1 << f3;
    for (int k = 0; k < size; k++) begin
      ba   = a + 32'(k);
      w    = ba & 32'hFFFF_FFFC;
      lane = int'(ba[1:0]);
      if (exp_nb == 0 || w != exp_addr[exp_nb-1]) begin
        exp_addr[exp_nb] = w;
        exp_nb++;
      end
      exp_be[exp_nb-1][lane]          = 1'b1;
      exp_data[exp_nb-1][lane*8 +: 8] = sv[k*8 +: 8];
    end
    if (!split_en && exp_nb == 2) begin
      exp_nb  = 0;
      exp_err = 1'b1;
      for (int i = 0; i < 2; i++) begin
        exp_addr[i] = '0; exp_be[i] = '0; exp_data[i] = '0;
      end
    end
  endtask

  // Issue one request to the splitting unit, ack beat0 after d0 stall cycles
  // and beat1 after d1, optionally toggling garbage inputs while busy.
  task automatic run_store(input string tag, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] sv, input int d0, input int d1, input bit noise);
    int bi, waited, lat;
    bit seen_done;
    compute_expected(ins, a, sv, 1'b1);
    @(negedge clk);
    instruction = ins; address = a; store_val = sv; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s ready: in_ready=%b required 1", tag, in_ready);
    end
    @(posedge clk); #1;
    if (noise) begin
      instruction = $urandom; address = $urandom; store_val = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    lat = (exp_nb == 0) ? 1 : exp_nb + 1 + d0 + ((exp_nb == 2) ? d1 : 0);
    bi = 0; waited = 0; seen_done = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen_done = 1'b1;
        in_valid  = 1'b0;
        mem_ack   = 1'b0;
        checks++;
        if (cyc != lat || err !== exp_err) begin
          failures++;
          $display("[TB] FAIL %s done: cycle=%0d err=%b required cycle=%0d err=%b",
                   tag, cyc, err, lat, exp_err);
        end
        checks++;
        if (bi != exp_nb || mem_req !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s beats: acked=%0d mem_req=%b required %0d beats mem_req=0",
                   tag, bi, mem_req, exp_nb);
        end
      end else if (mem_req === 1'b1) begin
        checks++;
        if (bi >= exp_nb) begin
          failures++;
          $display("[TB] FAIL %s extra beat %0d: addr=%h be=%b data=%h required none",
                   tag, bi, mem_addr, mem_be, mem_wdata);
        end else if (mem_addr !== exp_addr[bi] || mem_be !== exp_be[bi] ||
                     mem_wdata !== exp_data[bi]) begin
          failures++;
          $display("[TB] FAIL %s beat%0d: addr=%h be=%b data=%h required addr=%h be=%b data=%h",
                   tag, bi, mem_addr, mem_be, mem_wdata, exp_addr[bi], exp_be[bi], exp_data[bi]);
        end
        if (waited < ((bi == 0) ? d0 : d1)) begin
          mem_ack = 1'b0;
          waited++;
        end else begin
          mem_ack = 1'b1;
          bi++;
          waited = 0;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    if (!seen_done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: done never seen, required done at cycle %0d", tag, lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s after: done=%b in_ready=%b mem_req=%b required 0 1 0",
               tag, done, in_ready, mem_req);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0; mem_ack = 1'b0; mem_ack2 = 1'b0;
    instruction = '0; address = '0; store_val = '0;
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata, done, err, in_ready} !== {71'h0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset: req=%b addr=%h be=%b data=%h done=%b err=%b ready=%b required all 0, ready 1",
               mem_req, mem_addr, mem_be, mem_wdata, done, err, in_ready);
    end
    checks++;
    if ({mem_req2, mem_addr2, mem_be2, mem_wdata2, done2, err2, in_ready2} !== {71'h0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_nosplit: req=%b done=%b err=%b ready=%b required 0 0 0 1",
               mem_req2, done2, err2, in_ready2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_store("sb_1002", mk_instr(OP_STORE, 3'b000, 32'h0), 32'h0000_1002, 32'hA1B2_C3D4, 0, 0, 1'b0);
    run_store("sh_2003", mk_instr(OP_STORE, 3'b001, 32'h0), 32'h0000_2003, 32'h0000_BEEF, 0, 0, 1'b0);
    run_store("sw_3001", mk_instr(OP_STORE, 3'b010, 32'h0), 32'h0000_3001, 32'h1122_3344, 4, 0, 1'b0);
    run_store("sw_aligned", mk_instr(OP_STORE, 3'b010, 32'h0), 32'h0000_3010, 32'hDEAD_BEEF, 1, 0, 1'b0);
    run_store("sh_2002", mk_instr(OP_STORE, 3'b001, 32'h0), 32'h0000_2002, 32'h1234_5678, 0, 0, 1'b0);
  endtask

  task automatic test_illegal;
    run_store("f3_011", mk_instr(OP_STORE, 3'b011, 32'h0), 32'h0000_1000, 32'h5555_AAAA, 0, 0, 1'b0);
    run_store("f3_100", mk_instr(OP_STORE, 3'b100, 32'hFFFF_FFFF), 32'h0000_1001, 32'h1, 0, 0, 1'b0);
    run_store("load_op", mk_instr(OP_LOAD, 3'b010, 32'h0), 32'h0000_1000, 32'h2, 0, 0, 1'b0);
  endtask

  task automatic test_ack_ignored;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      if (mem_req !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (bad != 0 || mem_req !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_ack: %0d bad cycles, mem_req=%b done=%b required 0 0 0",
               bad, mem_req, done);
    end
  endtask

  task automatic test_wrap;
    run_store("sw_wrap", mk_instr(OP_STORE, 3'b010, 32'h0), 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 1, 1'b0);
    run_store("sh_wrap", mk_instr(OP_STORE, 3'b001, 32'h0), 32'hFFFF_FFFF, 32'h0000_9876, 1, 0, 1'b0);
  endtask

  task automatic test_no_split;
    logic [31:0] ins_tab [3];
    logic [31:0] adr_tab [3];
    int lat, beats;
    bit seen;
    ins_tab[0] = mk_instr(OP_STORE, 3'b010, 32'h0); adr_tab[0] = 32'h0000_4002;
    ins_tab[1] = mk_instr(OP_STORE, 3'b001, 32'h0); adr_tab[1] = 32'h0000_4003;
    ins_tab[2] = mk_instr(OP_STORE, 3'b000, 32'h0); adr_tab[2] = 32'h0000_4003;
    for (int t = 0; t < 3; t++) begin
      compute_expected(ins_tab[t], adr_tab[t], 32'h7788_99AA, 1'b0);
      lat = (exp_nb == 0) ? 1 : exp_nb + 1;
      @(negedge clk);
      instruction = ins_tab[t]; address = adr_tab[t]; store_val = 32'h7788_99AA;
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      beats = 0; seen = 1'b0;
      for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
        @(negedge clk);
        if (done2 === 1'b1) begin
          seen = 1'b1;
          mem_ack2 = 1'b0;
          checks++;
          if (cyc != lat || err2 !== exp_err || beats != exp_nb) begin
            failures++;
            $display("[TB] FAIL nosplit%0d: cycle=%0d err=%b beats=%0d required cycle=%0d err=%b beats=%0d",
                     t, cyc, err2, beats, lat, exp_err, exp_nb);
          end
        end else if (mem_req2 === 1'b1) begin
          checks++;
          if (beats >= exp_nb || mem_addr2 !== exp_addr[0] || mem_be2 !== exp_be[0] ||
              mem_wdata2 !== exp_data[0]) begin
            failures++;
            $display("[TB] FAIL nosplit%0d beat: addr=%h be=%b data=%h required %0d beats addr=%h be=%b data=%h",
                     t, mem_addr2, mem_be2, mem_wdata2, exp_nb, exp_addr[0], exp_be[0], exp_data[0]);
          end
          mem_ack2 = 1'b1;
          beats++;
        end else begin
          mem_ack2 = 1'b0;
        end
      end
      mem_ack2 = 1'b0;
      if (!seen) begin
        checks++;
        failures++;
        $display("[TB] FAIL nosplit%0d timeout: no done, required done at cycle %0d", t, lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_beat;
    int late_done;
    @(negedge clk);
    instruction = mk_instr(OP_STORE, 3'b010, 32'h0); address = 32'h0000_5001;
    store_val = 32'h0BAD_F00D; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5004) begin
      failures++;
      $display("[TB] FAIL midbeat_setup: mem_req=%b addr=%h required 1 00005004", mem_req, mem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata, done, err, in_ready} !== {71'h0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midbeat_clear: req=%b addr=%h be=%b data=%h done=%b err=%b ready=%b required all 0, ready 1",
               mem_req, mem_addr, mem_be, mem_wdata, done, err, in_ready);
    end
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) late_done++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0 || mem_req !== 1'b0) late_done++;
    end
    checks++;
    if (late_done != 0) begin
      failures++;
      $display("[TB] FAIL midbeat_nodone: %0d cycles with done/mem_req set, required 0", late_done);
    end
    run_store("post_reset_sw", mk_instr(OP_STORE, 3'b010, 32'h0), 32'h0000_0000, 32'h600D_CAFE, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? OP_LOAD : OP_STORE;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      run_store("random", mk_instr(op, f3, $urandom), a, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      run_store("busy_noise", mk_instr(OP_STORE, 3'($urandom_range(0, 2)), 32'h0),
                $urandom, $urandom, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_ack_ignored();
    test_wrap();
    test_no_split();
    test_reset_mid_beat();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
